// File: rtl/bayer_src_pkg.sv
// Shared constants and types for the synthetic Bayer pattern source.
// Optional noise feature: BAYER_PATTERN_NOISE_EN (LFSR seed/taps live here).
package bayer_src_pkg;

  localparam logic [1:0] PAT_FLAT  = 2'b00;
  localparam logic [1:0] PAT_VBAR  = 2'b01;
  localparam logic [1:0] PAT_CHECK = 2'b10;
  localparam logic [1:0] PAT_RAMP  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StHblank,
    StVblank
  } state_e;

  // Right-shifting Fibonacci LFSR, taps 16,14,13,11 map to bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Same value for all four Bayer phases, so the 2x2 average equals the pattern.
  function automatic logic [11:0] pattern_value(input logic [1:0]  pat,
                                                input logic [11:0] level,
                                                input logic [10:0] x,
                                                input logic        y5);
    logic [11:0] p;
    p = '0;
    unique case (pat)
      PAT_FLAT:  p = level;
      PAT_VBAR:  p = x[6] ? 12'hFFF : 12'h000;
      PAT_CHECK: p = (x[5] ^ y5) ? 12'hFFF : 12'h000;
      PAT_RAMP:  p = {x[10:0], 1'b0};
      default:   p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bayer_src_timing.sv
// Raster timing FSM: ACTIVE rows, HBLANK gaps, VBLANK tail.
// Outputs are the values the output registers take on the next edge, so that
// the top level can register pixel, valid and coordinates in a single stage.
module bayer_src_timing
  import bayer_src_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 960,
  parameter int unsigned H_BLANK  = 32,
  parameter int unsigned V_BLANK  = 2000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_free_run,
  output logic        o_nxt_dval,
  output logic [15:0] o_nxt_x,
  output logic [15:0] o_nxt_y,
  output logic        o_nxt_busy,
  output logic        o_nxt_done,
  output logic        o_frame_start
);

  localparam logic [15:0] HaLast = 16'(H_ACTIVE - 1);
  localparam logic [15:0] VaLast = 16'(V_ACTIVE - 1);
  localparam logic [15:0] HbLast = 16'(H_BLANK - 1);
  localparam logic [15:0] VbLast = 16'(V_BLANK - 1);

  state_e      r_state, w_state_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [15:0] r_row, w_row_d;
  logic        w_start;

  // State, phase counter and row register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_row   <= w_row_d;
    end
  end

  // Next-state logic; r_cnt is the column in ACTIVE and the blank count elsewhere.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_row_d   = r_row;
    w_start   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start || i_free_run) begin
          w_state_d = StActive;
          w_cnt_d   = '0;
          w_row_d   = '0;
          w_start   = 1'b1;
        end
      end
      StActive: begin
        if (r_cnt == HaLast) begin
          w_state_d = StHblank;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StHblank: begin
        if (r_cnt == HbLast) begin
          w_cnt_d = '0;
          if (r_row < VaLast) begin
            w_state_d = StActive;
            w_row_d   = r_row + 16'd1;
          end else begin
            w_state_d = StVblank;
          end
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StVblank: begin
        if (r_cnt == VbLast) begin
          w_cnt_d = '0;
          w_row_d = '0;
          if (i_free_run) begin
            w_state_d = StActive;
            w_start   = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Decode next-cycle outputs from the next state.
  always_comb begin
    o_nxt_dval    = (w_state_d == StActive);
    o_nxt_x       = o_nxt_dval ? w_cnt_d : 16'd0;
    o_nxt_y       = (w_state_d == StActive || w_state_d == StHblank) ? w_row_d : 16'd0;
    o_nxt_busy    = (w_state_d != StIdle);
    o_nxt_done    = (w_state_d == StVblank) && (w_cnt_d == VbLast);
    o_frame_start = w_start;
  end

endmodule

// File: rtl/bayer_pattern_source.sv
// Synthetic Bayer pixel transmitter: framed raster with one of four patterns.
// Optional macro BAYER_PATTERN_NOISE_EN adds LFSR noise to the low nibble.
module bayer_pattern_source
  import bayer_src_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 960,
  parameter int unsigned H_BLANK  = 32,
  parameter int unsigned V_BLANK  = 2000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic        iFree_Run,
  input  logic [1:0]  iPattern,
  input  logic [11:0] iLevel,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic        oBusy,
  output logic        oFrameDone,
  output logic [15:0] oFrame_Cont
);

  logic        w_dval_nxt;
  logic [15:0] w_x_nxt;
  logic [15:0] w_y_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_start;
  logic [1:0]  w_pat;
  logic [11:0] w_level;
  logic [11:0] w_pattern;
  logic [11:0] w_pixel;

  logic [1:0]  r_pat;
  logic [11:0] r_level;
  logic [11:0] r_data;
  logic        r_dval;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_frame_cont;

  bayer_src_timing #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_BLANK  (V_BLANK)
  ) u_timing (
    .i_clk         (iCLK),
    .i_rst         (iRST),
    .i_start       (iStart),
    .i_free_run    (iFree_Run),
    .o_nxt_dval    (w_dval_nxt),
    .o_nxt_x       (w_x_nxt),
    .o_nxt_y       (w_y_nxt),
    .o_nxt_busy    (w_busy_nxt),
    .o_nxt_done    (w_done_nxt),
    .o_frame_start (w_start)
  );

  // Latch pattern selection and level at every frame start.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_pat   <= PAT_FLAT;
      r_level <= '0;
    end else if (w_start) begin
      r_pat   <= iPattern;
      r_level <= iLevel;
    end
  end

  // The first pixel of a frame is emitted on the start edge, so bypass the latch then.
  always_comb begin
    w_pat     = w_start ? iPattern : r_pat;
    w_level   = w_start ? iLevel : r_level;
    w_pattern = pattern_value(w_pat, w_level, w_x_nxt[10:0], w_y_nxt[5]);
  end

`ifdef BAYER_PATTERN_NOISE_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // LFSR advances once per emitted pixel and is never reseeded by framing.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_dval_nxt) begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  // Pixel value with the current LFSR nibble folded in.
  always_comb begin
    w_lfsr_fb = ^(r_lfsr & LFSR_TAPS);
    w_pixel   = w_dval_nxt ? (w_pattern ^ {8'h00, r_lfsr[3:0]}) : 12'h000;
  end
`else
  // Pixel value, forced to zero outside valid cycles.
  always_comb begin
    w_pixel = w_dval_nxt ? w_pattern : 12'h000;
  end
`endif

  // Output registers and completed-frame counter.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_data       <= '0;
      r_dval       <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_frame_cont <= '0;
    end else begin
      r_data <= w_pixel;
      r_dval <= w_dval_nxt;
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_done_nxt) begin
        r_frame_cont <= r_frame_cont + 16'd1;
      end
    end
  end

  assign oDATA       = r_data;
  assign oDVAL       = r_dval;
  assign oX_Cont     = r_x;
  assign oY_Cont     = r_y;
  assign oBusy       = r_busy;
  assign oFrameDone  = r_done;
  assign oFrame_Cont = r_frame_cont;

endmodule

// File: tb/tb_bayer_pattern_source.sv
// Directed bench with a pixel scoreboard for bayer_pattern_source.
// Instance A: 8x4 raster (framing, free-run, latching, reset).
// Instance B: 128x64 raster (vertical bars and checkerboard).
module tb_bayer_pattern_source;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HB = 2;
  localparam int VB = 5;
  localparam int HA2 = 128;
  localparam int VA2 = 64;
  localparam int FRAME_A = VA * (HA + HB) + VB;
  localparam int FRAME_B = VA2 * (HA2 + HB) + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a, free_a, start_b, free_b;
  logic [1:0]  pat_a, pat_b;
  logic [11:0] lvl_a, lvl_b;
  logic [11:0] data_a, data_b;
  logic        dval_a, dval_b, busy_a, busy_b, done_a, done_b;
  logic [15:0] x_a, y_a, fc_a, x_b, y_b, fc_b;

  bayer_pattern_source #(
    .H_ACTIVE (HA), .V_ACTIVE (VA), .H_BLANK (HB), .V_BLANK (VB)
  ) u_dut_a (
    .iCLK (clk), .iRST (rst), .iStart (start_a), .iFree_Run (free_a),
    .iPattern (pat_a), .iLevel (lvl_a), .oDATA (data_a), .oDVAL (dval_a),
    .oX_Cont (x_a), .oY_Cont (y_a), .oBusy (busy_a), .oFrameDone (done_a),
    .oFrame_Cont (fc_a)
  );

  bayer_pattern_source #(
    .H_ACTIVE (HA2), .V_ACTIVE (VA2), .H_BLANK (HB), .V_BLANK (VB)
  ) u_dut_b (
    .iCLK (clk), .iRST (rst), .iStart (start_b), .iFree_Run (free_b),
    .iPattern (pat_b), .iLevel (lvl_b), .oDATA (data_b), .oDVAL (dval_b),
    .oX_Cont (x_b), .oY_Cont (y_b), .oBusy (busy_b), .oFrameDone (done_b),
    .oFrame_Cont (fc_b)
  );

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [11:0] d;
  } pix_t;

  pix_t q_a[$];
  pix_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;
  logic [15:0] lfsr_a, lfsr_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_pix(input logic [1:0] pat, input logic [11:0] lvl,
                                          input logic [15:0] x, input logic [15:0] y);
    case (pat)
      2'b00:   return lvl;
      2'b01:   return x[6] ? 12'hFFF : 12'h000;
      2'b10:   return (x[5] ^ y[5]) ? 12'hFFF : 12'h000;
      default: return {x[10:0], 1'b0};
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic push_frame(input bit sel, input int w, input int h,
                            input logic [1:0] pat, input logic [11:0] lvl);
    pix_t e;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        e.x = 16'(xx);
        e.y = 16'(yy);
        e.d = ref_pix(pat, lvl, 16'(xx), 16'(yy));
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input bit sel, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) ok = 1'b1;
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  // Scoreboard monitor for instance A.
  always @(negedge clk) begin
    pix_t e;
    logic [11:0] exp_d;
    if (rst) begin
      lfsr_a <= 16'hACE1;
    end else begin
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      if (dval_a) begin
        check("a_expected_pixel", 64'(q_a.size() != 0), 64'd1);
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
`ifdef BAYER_PATTERN_NOISE_EN
          exp_d = e.d ^ {8'h00, lfsr_a[3:0]};
          lfsr_a <= lfsr_step(lfsr_a);
`else
          exp_d = e.d;
`endif
          check("a_pixel_xyd", 64'({x_a, y_a, data_a}), 64'({e.x, e.y, exp_d}));
        end
      end
    end
  end

  // Scoreboard monitor for instance B.
  always @(negedge clk) begin
    pix_t e;
    logic [11:0] exp_d;
    if (rst) begin
      lfsr_b <= 16'hACE1;
    end else begin
      if (done_b) done_cnt_b <= done_cnt_b + 1;
      if (dval_b) begin
        check("b_expected_pixel", 64'(q_b.size() != 0), 64'd1);
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
`ifdef BAYER_PATTERN_NOISE_EN
          exp_d = e.d ^ {8'h00, lfsr_b[3:0]};
          lfsr_b <= lfsr_step(lfsr_b);
`else
          exp_d = e.d;
`endif
          check("b_pixel_xyd", 64'({x_b, y_b, data_b}), 64'({e.x, e.y, exp_d}));
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int base;
    start_a = 0; free_a = 0; pat_a = 0; lvl_a = 0;
    start_b = 0; free_b = 0; pat_b = 0; lvl_b = 0;

    // Reset values
    repeat (3) @(negedge clk);
    check("a_reset_outputs", 64'({data_a, dval_a, x_a, y_a, busy_a, done_a, fc_a}), 64'd0);
    check("b_reset_outputs", 64'({data_b, dval_b, x_b, y_b, busy_b, done_b, fc_b}), 64'd0);
    rst = 0;
    @(negedge clk);

    // Single flat frame; frame is FRAME_A cycles, done on its last cycle
    pat_a = 2'b00; lvl_a = 12'h123; start_a = 1;
    push_frame(0, HA, VA, 2'b00, 12'h123);
    @(negedge clk);
    start_a = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (dval_a) got = 1'b1;
      else @(negedge clk);
    end
    check("t1_first_valid_seen", 64'(got), 64'd1);
    check("t1_busy_in_frame", 64'(busy_a), 64'd1);
    for (int k = 0; k < FRAME_A; k++) begin
      check("t1_dval_window", 64'(dval_a), 64'((k < VA * (HA + HB)) && (k % (HA + HB) < HA)));
      check("t1_done_window", 64'(done_a), 64'(k == FRAME_A - 1));
      @(negedge clk);
    end
    check("t1_frame_cont", 64'(fc_a), 64'd1);
    check("t1_busy_idle", 64'(busy_a), 64'd0);
    check("t1_done_count", 64'(done_cnt_a), 64'd1);
    check("t1_queue_drained", 64'(q_a.size()), 64'd0);

    // Vertical bars and checkerboard on the large raster
    pat_b = 2'b01; start_b = 1;
    push_frame(1, HA2, VA2, 2'b01, 12'h000);
    @(negedge clk);
    start_b = 0;
    wait_done(1, FRAME_B + 10, "t2_vbar_done");
    repeat (3) @(negedge clk);
    pat_b = 2'b10; start_b = 1;
    push_frame(1, HA2, VA2, 2'b10, 12'h000);
    @(negedge clk);
    start_b = 0;
    wait_done(1, FRAME_B + 10, "t3_check_done");
    repeat (3) @(negedge clk);
    check("t3_frame_cont", 64'(fc_b), 64'd2);
    check("t3_queue_drained", 64'(q_b.size()), 64'd0);
    check("t3_busy_idle", 64'(busy_b), 64'd0);

    // Free-run for three frames, dropped mid-frame 3
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    check("t4_reset_frame_cont", 64'(fc_a), 64'd0);
    base = done_cnt_a;
    pat_a = 2'b11; free_a = 1;
    for (int f = 0; f < 3; f++) push_frame(0, HA, VA, 2'b11, 12'h000);
    wait_done(0, FRAME_A + 10, "t4_frame1_done");
    wait_done(0, FRAME_A + 10, "t4_frame2_done");
    repeat (10) @(negedge clk);
    free_a = 0;
    wait_done(0, FRAME_A + 10, "t4_frame3_done");
    repeat (3) @(negedge clk);
    check("t4_busy_idle", 64'(busy_a), 64'd0);
    check("t4_frame_cont", 64'(fc_a), 64'd3);
    repeat (60) @(negedge clk);
    check("t4_done_count", 64'(done_cnt_a - base), 64'd3);
    check("t4_queue_drained", 64'(q_a.size()), 64'd0);

    // Mid-frame pattern change and start pulse are ignored
    base = done_cnt_a;
    pat_a = 2'b00; lvl_a = 12'h3C0; start_a = 1;
    push_frame(0, HA, VA, 2'b00, 12'h3C0);
    @(negedge clk);
    start_a = 0;
    repeat (5) @(negedge clk);
    pat_a = 2'b11; lvl_a = 12'h000; start_a = 1;
    @(negedge clk);
    start_a = 0;
    wait_done(0, FRAME_A + 10, "t5_frame_done");
    repeat (30) @(negedge clk);
    check("t5_frame_cont", 64'(fc_a), 64'd4);
    check("t5_busy_idle", 64'(busy_a), 64'd0);
    check("t5_single_frame", 64'(done_cnt_a - base), 64'd1);
    check("t5_queue_drained", 64'(q_a.size()), 64'd0);

    // Reset asserted during row 2
    pat_a = 2'b00; lvl_a = 12'h555; start_a = 1;
    push_frame(0, HA, VA, 2'b00, 12'h555);
    @(negedge clk);
    start_a = 0;
    got = 1'b0;
    for (int i = 0; i < FRAME_A && !got; i++) begin
      if (dval_a && y_a == 16'd2) got = 1'b1;
      else @(negedge clk);
    end
    check("t5_reached_row2", 64'(got), 64'd1);
    base = done_cnt_a;
    #1 rst = 1;
    @(posedge clk);
    #1;
    check("t5_reset_outputs", 64'({data_a, dval_a, x_a, y_a, busy_a, done_a, fc_a}), 64'd0);
    q_a.delete();
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    check("t5_no_done_after_reset", 64'(done_cnt_a - base), 64'd0);
    check("t5_idle_after_reset", 64'({busy_a, dval_a, fc_a}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
